// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the stall/flush sequencer.
// master = sequencer (drives stage controls), slave = pipeline datapath.
interface pipe_hazard_ctrl_if #(
  parameter int PC_W = 64
);
  logic            imem_stall;
  logic            dmem_stall;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_use_rs1;
  logic            id_use_rs2;
  logic [4:0]      ex_dst;
  logic            ex_memread;
  logic            ex_muldiv_start;
  logic            ex_branch_taken;
  logic [PC_W-1:0] ex_branch_target;

  logic            stall_if;
  logic            stall_id;
  logic            stall_ex;
  logic            stall_mem;
  logic            flush_if;
  logic            flush_id;
  logic            flush_ex;
  logic            flush_mem;
  logic            redirect_valid;
  logic [PC_W-1:0] redirect_pc;
  logic            muldiv_done;

  modport master (
    input  imem_stall, dmem_stall, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_dst, ex_memread, ex_muldiv_start, ex_branch_taken, ex_branch_target,
    output stall_if, stall_id, stall_ex, stall_mem,
           flush_if, flush_id, flush_ex, flush_mem,
           redirect_valid, redirect_pc, muldiv_done
  );

  modport slave (
    output imem_stall, dmem_stall, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           ex_dst, ex_memread, ex_muldiv_start, ex_branch_taken, ex_branch_target,
    input  stall_if, stall_id, stall_ex, stall_mem,
           flush_if, flush_id, flush_ex, flush_mem,
           redirect_valid, redirect_pc, muldiv_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory waits, mul/div occupancy,
// load-use hazards and branch redirects. Optional perf counters: PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 64,
  parameter int PC_W       = 64
) (
  input  logic                clk,
  input  logic                reset,
  pipe_hazard_ctrl_if.master  bus
`ifdef PIPE_HAZARD_PERF_EN
  ,
  output logic [63:0]         perf_dstall_cnt,
  output logic [63:0]         perf_mstall_cnt,
  output logic [63:0]         perf_luse_cnt,
  output logic [63:0]         perf_flush_cnt
`endif
);

  localparam int              CNT_W    = $clog2(MULDIV_LAT);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic            pend;
  logic [PC_W-1:0] pend_pc;

  logic dstall;
  logic luse;
  logic mstall;
  logic br;
  logic luse_eff;
  logic done;

  always_comb begin
    dstall = bus.dmem_stall;
    luse   = bus.ex_memread && (bus.ex_dst != 5'd0) &&
             (((bus.ex_dst == bus.id_rs1) && bus.id_use_rs1) ||
              ((bus.ex_dst == bus.id_rs2) && bus.id_use_rs2));
    // The start cycle already occupies EX; the cnt==0 cycle releases the stall.
    mstall = ((state == IDLE) && bus.ex_muldiv_start && !dstall) ||
             ((state == BUSY) && (cnt != '0));
    done   = (state == BUSY) && (cnt == '0) && !dstall;
    br     = bus.ex_branch_taken && !dstall && !mstall && (state == IDLE);
    // A taken branch squashes the ID instruction, so its load-use stall is moot.
    luse_eff = luse && !dstall && !br;
  end

  always_comb begin
    bus.stall_if       = 1'b0;
    bus.stall_id       = 1'b0;
    bus.stall_ex       = 1'b0;
    bus.stall_mem      = 1'b0;
    bus.flush_if       = 1'b1;
    bus.flush_id       = 1'b1;
    bus.flush_ex       = 1'b1;
    bus.flush_mem      = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.muldiv_done    = 1'b0;
    if (reset) begin
      bus.stall_if       = dstall || mstall || luse_eff;
      bus.stall_id       = dstall || mstall || luse_eff;
      bus.stall_ex       = dstall || mstall;
      bus.stall_mem      = dstall;
      bus.flush_if       = br || pend || bus.imem_stall;
      bus.flush_id       = br || luse_eff;
      bus.flush_ex       = mstall;
      bus.flush_mem      = dstall;
      bus.redirect_valid = br || pend;
      if (br)
        bus.redirect_pc = bus.ex_branch_target;
      else if (pend)
        bus.redirect_pc = pend_pc;
      bus.muldiv_done    = done;
    end
  end

  // Control state: mul/div occupancy FSM and pending-redirect flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      pend  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.ex_muldiv_start && !dstall) begin
            state <= BUSY;
            cnt   <= CNT_LOAD;
          end
        end
        BUSY: begin
          if (!dstall) begin
            if (cnt == '0)
              state <= IDLE;
            else
              cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase

      if (br && bus.imem_stall)
        pend <= 1'b1;
      else if (!bus.imem_stall)
        pend <= 1'b0;
    end
  end

  // Redirect target capture; only observed while pend is set.
  always_ff @(posedge clk) begin
    if (br && bus.imem_stall)
      pend_pc <= bus.ex_branch_target;
  end

`ifdef PIPE_HAZARD_PERF_EN
  function automatic logic [63:0] sat_inc(input logic [63:0] v);
    return (&v) ? v : v + 64'd1;
  endfunction

  // Each cycle is credited to the highest active priority level only.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_dstall_cnt <= '0;
      perf_mstall_cnt <= '0;
      perf_luse_cnt   <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (dstall)
        perf_dstall_cnt <= sat_inc(perf_dstall_cnt);
      else if (mstall)
        perf_mstall_cnt <= sat_inc(perf_mstall_cnt);
      else if (luse_eff)
        perf_luse_cnt <= sat_inc(perf_luse_cnt);
      else if (br)
        perf_flush_cnt <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (MULDIV_LAT=4): control vector checked once per cycle.
module tb_pipe_hazard_ctrl;
  localparam int PC_W = 64;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  pipe_hazard_ctrl_if #(.PC_W(PC_W)) bus ();

`ifdef PIPE_HAZARD_PERF_EN
  logic [63:0] perf_dstall_cnt, perf_mstall_cnt, perf_luse_cnt, perf_flush_cnt;
`endif

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .PC_W(PC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PIPE_HAZARD_PERF_EN
    ,
    .perf_dstall_cnt (perf_dstall_cnt),
    .perf_mstall_cnt (perf_mstall_cnt),
    .perf_luse_cnt   (perf_luse_cnt),
    .perf_flush_cnt  (perf_flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {stall_if, stall_id, stall_ex, stall_mem, flush_if, flush_id, flush_ex, flush_mem, redirect_valid, muldiv_done}
  logic [9:0] ctl;
  assign ctl = {bus.stall_if, bus.stall_id, bus.stall_ex, bus.stall_mem,
                bus.flush_if, bus.flush_id, bus.flush_ex, bus.flush_mem,
                bus.redirect_valid, bus.muldiv_done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic exp_cyc(input string tag, input logic [9:0] e, input logic [63:0] pc);
    #1;
    chk({tag, ".ctl"}, {54'd0, ctl}, {54'd0, e});
    chk({tag, ".pc"}, bus.redirect_pc, pc);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.imem_stall       = 1'b0;
    bus.dmem_stall       = 1'b0;
    bus.id_rs1           = 5'd0;
    bus.id_rs2           = 5'd0;
    bus.id_use_rs1       = 1'b0;
    bus.id_use_rs2       = 1'b0;
    bus.ex_dst           = 5'd0;
    bus.ex_memread       = 1'b0;
    bus.ex_muldiv_start  = 1'b0;
    bus.ex_branch_taken  = 1'b0;
    bus.ex_branch_target = '0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b0;
    clear_in();
    exp_cyc("reset", 10'b0000_1111_00, 64'h0);
    tick();
    tick();
    reset = 1'b1;
    exp_cyc("idle", 10'b0000_0000_00, 64'h0);

    // Load-use via rs1, lasting exactly one cycle
    tick();
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd5; bus.id_rs1 = 5'd5; bus.id_use_rs1 = 1'b1;
    exp_cyc("luse_rs1", 10'b1100_0100_00, 64'h0);
    tick();
    clear_in();
    exp_cyc("luse_after", 10'b0000_0000_00, 64'h0);
    tick();
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd0; bus.id_rs1 = 5'd0; bus.id_use_rs1 = 1'b1;
    exp_cyc("luse_x0", 10'b0000_0000_00, 64'h0);
    tick();
    clear_in();
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd7; bus.id_rs2 = 5'd7; bus.id_use_rs2 = 1'b1;
    exp_cyc("luse_rs2", 10'b1100_0100_00, 64'h0);
    tick();
    bus.id_use_rs2 = 1'b0;
    exp_cyc("luse_rs2_unused", 10'b0000_0000_00, 64'h0);

    // Taken branch
    tick();
    clear_in();
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h8000_0100;
    exp_cyc("branch", 10'b0000_1100_10, 64'h8000_0100);
    tick();
    clear_in();
    exp_cyc("branch_after", 10'b0000_0000_00, 64'h0);
    tick();
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h8000_0180;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd3; bus.id_rs1 = 5'd3; bus.id_use_rs1 = 1'b1;
    exp_cyc("branch_over_luse", 10'b0000_1100_10, 64'h8000_0180);

    // Mul/div, 4-cycle occupancy; restart and branch while busy are ignored
    tick();
    clear_in();
    bus.ex_muldiv_start = 1'b1;
    exp_cyc("md_c0", 10'b1110_0010_00, 64'h0);
    tick();
    clear_in();
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h1234;
    exp_cyc("md_c1", 10'b1110_0010_00, 64'h0);
    tick();
    clear_in();
    bus.ex_muldiv_start = 1'b1;
    exp_cyc("md_c2", 10'b1110_0010_00, 64'h0);
    tick();
    clear_in();
    exp_cyc("md_c3_done", 10'b0000_0000_01, 64'h0);
    tick();
    exp_cyc("md_c4_idle", 10'b0000_0000_00, 64'h0);

    // Mul/div with a two-cycle memory wait in the middle
    tick();
    bus.ex_muldiv_start = 1'b1;
    exp_cyc("mdd_c0", 10'b1110_0010_00, 64'h0);
    tick();
    clear_in();
    bus.dmem_stall = 1'b1;
    exp_cyc("mdd_c1", 10'b1111_0011_00, 64'h0);
    tick();
    exp_cyc("mdd_c2", 10'b1111_0011_00, 64'h0);
    tick();
    clear_in();
    exp_cyc("mdd_c3", 10'b1110_0010_00, 64'h0);
    tick();
    exp_cyc("mdd_c4", 10'b1110_0010_00, 64'h0);
    tick();
    exp_cyc("mdd_c5_done", 10'b0000_0000_01, 64'h0);
    tick();
    exp_cyc("mdd_c6_idle", 10'b0000_0000_00, 64'h0);

    // Memory wait dominates load-use and branch
    tick();
    bus.dmem_stall = 1'b1;
    bus.ex_memread = 1'b1; bus.ex_dst = 5'd9; bus.id_rs1 = 5'd9; bus.id_use_rs1 = 1'b1;
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h8000_0400;
    exp_cyc("dmem_dom", 10'b1111_0001_00, 64'h0);

    // Redirect arriving while fetch is blocked, then overwritten by a newer branch
    tick();
    clear_in();
    bus.imem_stall = 1'b1;
    exp_cyc("pend_c0", 10'b0000_1000_00, 64'h0);
    tick();
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h8000_0200;
    exp_cyc("pend_c1", 10'b0000_1100_10, 64'h8000_0200);
    tick();
    bus.ex_branch_target = 64'h8000_0300;
    exp_cyc("pend_c2", 10'b0000_1100_10, 64'h8000_0300);
    tick();
    bus.ex_branch_taken = 1'b0; bus.ex_branch_target = '0;
    exp_cyc("pend_c3", 10'b0000_1000_10, 64'h8000_0300);
    tick();
    bus.imem_stall = 1'b0;
    exp_cyc("pend_c4", 10'b0000_1000_10, 64'h8000_0300);
    tick();
    exp_cyc("pend_c5", 10'b0000_0000_00, 64'h0);

    // Reset while BUSY with a pending redirect
    tick();
    bus.imem_stall = 1'b1;
    bus.ex_branch_taken = 1'b1; bus.ex_branch_target = 64'h8000_0500;
    exp_cyc("rst_setup_br", 10'b0000_1100_10, 64'h8000_0500);
    tick();
    bus.ex_branch_taken = 1'b0; bus.ex_branch_target = '0;
    bus.ex_muldiv_start = 1'b1;
    exp_cyc("rst_setup_md", 10'b1110_1010_10, 64'h8000_0500);
    tick();
    bus.ex_muldiv_start = 1'b0;
    exp_cyc("rst_setup_busy", 10'b1110_1010_10, 64'h8000_0500);
    reset = 1'b0;
    exp_cyc("rst_async", 10'b0000_1111_00, 64'h0);
    tick();
    clear_in();
    reset = 1'b1;
    exp_cyc("rst_rel_c0", 10'b0000_0000_00, 64'h0);
    for (int i = 1; i < 5; i++) begin
      tick();
      exp_cyc($sformatf("rst_rel_c%0d", i), 10'b0000_0000_00, 64'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
